// File: rtl/npuarc_rtt_atb_funnel.sv
// ---------------------------------------------------------------------------
// npuarc_rtt_atb_funnel
//
// Collects fixed-width trace messages from NUM_CH producers, buffers each
// channel in a private FIFO and serialises whole messages, round-robin,
// onto a single ATB master port as ATW-bit beats tagged with the channel's
// ATID. Also handles ATB flush (afvalid/afready) and fans a syncreq rising
// edge out to every producer.
//
// Ports
//   rtt_clk     : clock
//   atresetn    : asynchronous active-low reset
//   req/data    : per-channel write request and message (DATA_W bits each)
//   ack         : per-channel write accepted this cycle
//   i_atid      : per-channel 7-bit ATID
//   busy        : channel has buffered data or is being transmitted
//   atvalid/atready/atdata/atid/atbytes : ATB master data channel
//   afvalid/afready : ATB flush handshake
//   syncreq     : ATB sync request in
//   rttsyncreq  : one-cycle per-channel sync pulse out
// ---------------------------------------------------------------------------
module npuarc_rtt_atb_funnel #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 120,
    parameter int ATW    = 32,
    parameter int DEPTH  = 2,
    parameter int ATB_BW = (ATW > 8) ? $clog2(ATW / 8) : 1
) (
    input  logic                     rtt_clk,
    input  logic                     atresetn,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*DATA_W-1:0] data,
    output logic [NUM_CH-1:0]        ack,
    input  logic [NUM_CH*7-1:0]      i_atid,
    output logic [NUM_CH-1:0]        busy,
    input  logic                     atready,
    output logic                     atvalid,
    output logic [ATW-1:0]           atdata,
    output logic [6:0]               atid,
    output logic [ATB_BW-1:0]        atbytes,
    input  logic                     afvalid,
    output logic                     afready,
    input  logic                     syncreq,
    output logic [NUM_CH-1:0]        rttsyncreq
);

    localparam int BEATS  = (DATA_W + ATW - 1) / ATW;
    localparam int PAD_W  = BEATS * ATW;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [ATB_BW-1:0] FULL_BYTES = ATB_BW'(ATW / 8 - 1);
    localparam logic [ATB_BW-1:0] LAST_BYTES = ATB_BW'((DATA_W - (BEATS - 1) * ATW) / 8 - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t              state_q;
    logic [CH_W-1:0]     grant_q;
    logic [CH_W-1:0]     rr_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                atvalid_q;
    logic [6:0]          atid_q;
    logic                flush_q;
    logic                afready_q;
    logic                sync_prev_q;
    logic                rttsync_q;

    logic [NUM_CH-1:0]              full;
    logic [NUM_CH-1:0]              nonempty;
    logic [NUM_CH-1:0]              pop;
    logic [NUM_CH-1:0][DATA_W-1:0]  head_all;

    logic                pick_found;
    logic [CH_W-1:0]     pick_ch;
    logic [CH_W-1:0]     rr_d;
    logic                last_hs;
    logic                flush_done;
    logic [PAD_W-1:0]    head_pad;
    logic [ATW-1:0]      beat_word [BEATS];

    // Gating with the reset keeps ack low while the block is held in reset.
    assign ack = req & ~full & {NUM_CH{atresetn}};

    // -----------------------------------------------------------------------
    // Per-channel FIFOs. Full is taken from the registered count, so a pop
    // in the same cycle never frees a slot for that cycle's write.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q;
        logic [PTR_W-1:0]  rd_ptr_q;
        logic [CNT_W-1:0]  count_q;

        always_ff @(posedge rtt_clk) begin
            if (ack[gi]) begin
                mem_q[wr_ptr_q] <= data[gi*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge rtt_clk or negedge atresetn) begin
            if (!atresetn) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (ack[gi]) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop[gi]) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                case ({ack[gi], pop[gi]})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end

        assign full[gi]     = (count_q == CNT_W'(DEPTH));
        assign nonempty[gi] = (count_q != '0);
        assign head_all[gi] = mem_q[rd_ptr_q];
        assign busy[gi]     = nonempty[gi] | ((state_q == ST_SEND) && (grant_q == CH_W'(gi)));
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: first non-empty channel at or above rr_q, wrapping.
    // -----------------------------------------------------------------------
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_ch    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_q) + k) % NUM_CH;
            if (!pick_found && nonempty[idx]) begin
                pick_found = 1'b1;
                pick_ch    = CH_W'(idx);
            end
        end
    end

    assign rr_d    = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
    assign last_hs = (state_q == ST_SEND) && atready && (beat_q == LAST_BEAT);

    always_comb begin
        pop = '0;
        if (last_hs) begin
            pop[grant_q] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Beat slicing of the granted FIFO head. The head entry cannot change
    // until it is popped, so the data stays stable under backpressure.
    // -----------------------------------------------------------------------
    assign head_pad = PAD_W'(head_all[grant_q]);

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        assign beat_word[gi] = head_pad[gi*ATW +: ATW];
    end

    assign atvalid = atvalid_q;
    assign atdata  = atvalid_q ? beat_word[beat_q] : '0;
    assign atid    = atvalid_q ? atid_q : 7'd0;
    assign atbytes = atvalid_q ? ((beat_q == LAST_BEAT) ? LAST_BYTES : FULL_BYTES) : '0;

    // -----------------------------------------------------------------------
    // Transmit FSM. Returning to IDLE after each message guarantees the
    // one-cycle atvalid gap and a fresh arbitration per message.
    // -----------------------------------------------------------------------
    always_ff @(posedge rtt_clk or negedge atresetn) begin
        if (!atresetn) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            beat_q    <= '0;
            atvalid_q <= 1'b0;
            atid_q    <= 7'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_q   <= pick_ch;
                        beat_q    <= '0;
                        atid_q    <= i_atid[int'(pick_ch)*7 +: 7];
                        atvalid_q <= 1'b1;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (atready) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q    <= '0;
                            rr_q      <= rr_d;
                            atvalid_q <= 1'b0;
                            state_q   <= ST_IDLE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Flush: completion also waits for no write landing this cycle, so data
    // arriving during a flush extends it. afvalid is ignored in the cycle
    // afready is high so a master still holding afvalid gets one pulse.
    // -----------------------------------------------------------------------
    assign flush_done = flush_q && (state_q == ST_IDLE) && !(|nonempty) && !(|ack);

    always_ff @(posedge rtt_clk or negedge atresetn) begin
        if (!atresetn) begin
            flush_q   <= 1'b0;
            afready_q <= 1'b0;
        end else begin
            afready_q <= flush_done;
            if (flush_done) begin
                flush_q <= 1'b0;
            end else if (afvalid && !afready_q) begin
                flush_q <= 1'b1;
            end
        end
    end

    assign afready = afready_q;

    // Sync fan-out: one pulse per rising edge of syncreq.
    always_ff @(posedge rtt_clk or negedge atresetn) begin
        if (!atresetn) begin
            sync_prev_q <= 1'b0;
            rttsync_q   <= 1'b0;
        end else begin
            sync_prev_q <= syncreq;
            rttsync_q   <= syncreq & ~sync_prev_q;
        end
    end

    assign rttsyncreq = {NUM_CH{rttsync_q}};

endmodule
